// File: rtl/am_1bit_modulator.sv
// AM transmitter: buffered 8-bit audio scales the envelope of a square-wave NCO carrier,
// and a first-order sigma-delta turns the result into a 1-bit RF bitstream.
module am_1bit_modulator #(
  parameter int PHASE_W = 24,
  parameter int DECIM   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic [7:0]         mod_idx,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               clr_underrun,
  output logic               underrun,
  output logic               carrier_out,
  output logic               rf_out
);

  localparam int DIV_W = $clog2(DECIM);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECIM - 1);

  logic [PHASE_W-1:0] phase;
  logic [DIV_W-1:0]   div;
  logic [7:0]         hold;
  logic               hold_full;
  logic signed [7:0]  active;
  logic [7:0]         env_q;
  logic signed [10:0] acc;

  logic               tick;
  logic               accept;
  logic signed [15:0] prod;
  logic [7:0]         env_next;
  logic signed [10:0] env_ext;
  logic signed [10:0] m_val;
  logic signed [10:0] fb;
  logic signed [10:0] sd_sum;

  // Valid/ready: a sample transfers on any clock edge where in_valid & in_ready are both
  // high. in_ready depends only on the holding-slot state, never combinationally on in_valid,
  // and stays live while en is low so one sample can be parked during a freeze.
  assign in_ready = ~hold_full;
  assign accept   = in_valid & in_ready;
  assign tick     = en & (div == DIV_LAST);

  assign carrier_out = phase[PHASE_W-1];

  // Signed audio times zero-extended index; the arithmetic shift floors toward -inf,
  // so the offset envelope spans 0..254 and never wraps.
  assign prod     = $signed({{8{active[7]}}, active}) * $signed({8'd0, mod_idx});
  assign env_next = 8'((prod >>> 8) + 16'sd128);

  assign env_ext = $signed({3'b000, env_q});
  assign m_val   = carrier_out ? -env_ext : env_ext;
  assign fb      = rf_out ? 11'sd255 : -11'sd255;
  assign sd_sum  = acc + m_val - fb;

  // Carrier NCO, sample-period divider, envelope register and sigma-delta loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= '0;
      div    <= '0;
      env_q  <= 8'd128;
      acc    <= '0;
      rf_out <= 1'b0;
    end else if (en) begin
      phase  <= phase + tune_word;
      div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      env_q  <= env_next;
      acc    <= sd_sum;
      rf_out <= ~sd_sum[10];
    end
  end

  // Holding slot and active sample. Accept only happens with the slot empty and the
  // tick only drains a full slot, so the two never fight over hold_full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      active    <= '0;
    end else begin
      if (tick && hold_full) begin
        active    <= hold;
        hold_full <= 1'b0;
      end
      if (accept) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
    end
  end

  // Sticky underrun; a new underrun in the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
    end else begin
      if (clr_underrun)
        underrun <= 1'b0;
      if (tick && !hold_full)
        underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_am_1bit_modulator.sv
// Directed bench for am_1bit_modulator: per-cycle port expectations and per-sample
// active/envelope expectations are queued by the stimulus and popped by monitors.
module tb_am_1bit_modulator;

  localparam int PHASE_W = 24;
  localparam int DECIM   = 64;

  localparam logic [3:0] M_RDY = 4'b1000;
  localparam logic [3:0] M_UND = 4'b0100;
  localparam logic [3:0] M_CAR = 4'b0010;
  localparam logic [3:0] M_RF  = 4'b0001;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [PHASE_W-1:0] tune_word;
  logic [7:0]         mod_idx;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               clr_underrun;
  logic               underrun;
  logic               carrier_out;
  logic               rf_out;

  am_1bit_modulator #(.PHASE_W(PHASE_W), .DECIM(DECIM)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tune_word    (tune_word),
    .mod_idx      (mod_idx),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .clr_underrun (clr_underrun),
    .underrun     (underrun),
    .carrier_out  (carrier_out),
    .rf_out       (rf_out)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_q[$];   // {mask, value} over {in_ready, underrun, carrier_out, rf_out}
  logic [15:0] act_q[$];   // {expected env_q, expected active} per loaded sample
  int n_tests = 0;
  int n_fail  = 0;
  int nco_k   = 0;         // enabled clocks since reset; tune_word is fixed at 2^20

  function automatic string bit_name(input int b);
    case (b)
      3:       return "in_ready";
      2:       return "underrun";
      1:       return "carrier_out";
      default: return "rf_out";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_tests++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, got, lo, hi, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge with inputs already set: queues the expected port values for
  // the state after the next rising edge, then advances to the following falling edge.
  // The carrier expectation follows from nco_k: phase = k * 2^20, so its MSB is k[3].
  task automatic step(input logic [3:0] m, input logic [3:0] v);
    logic car;
    if (en && !rst) nco_k++;
    car = rst ? 1'b0 : nco_k[3];
    exp_q.push_back({m | M_CAR, (v & ~M_CAR) | {2'b00, car, 1'b0}});
    @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  initial begin
    logic [7:0] e;
    logic [3:0] obs;
    logic       bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        obs = {in_ready, underrun, carrier_out, rf_out};
        bad = 1'b0;
        for (int b = 0; b < 4; b++) begin
          if (e[4+b] && (obs[b] !== e[b])) begin
            bad = 1'b1;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", bit_name(b), obs[b], e[b], $time);
          end
        end
        n_tests++;
        if (bad) n_fail++;
      end
    end
  end

  // A rising in_ready means the tick just moved the held sample into active.
  initial begin
    logic        prev_rdy;
    logic [15:0] e2;
    prev_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_rdy = 1'b1;
      end else begin
        if (in_ready && !prev_rdy) begin
          if (act_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_load: got active %0h expected no load (t=%0t)", dut.active, $time);
          end else begin
            e2 = act_q.pop_front();
            check("active", {24'd0, dut.active}, {24'd0, e2[7:0]});
            @(posedge clk);
            #1;
            check("env_q", {24'd0, dut.env_q}, {24'd0, e2[15:8]});
          end
        end
        prev_rdy = in_ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [7:0]  seq     [8] = '{8'h10, 8'hF0, 8'h40, 8'hC0, 8'h01, 8'hFF, 8'h7F, 8'h80};
  logic [7:0]  env_tab [8] = '{8'd143, 8'd112, 8'd191, 8'd64, 8'd128, 8'd127, 8'd254, 8'd0};

  initial begin
    logic [15:0] rf_seq;
    logic [31:0] win;
    logic        rf_frz;
    logic        acc_now;
    int ones0, ones1, bad_pairs, idx;

    // Hand-run sigma-delta from reset with env_q=128: rf_out after enabled clocks 1..16.
    rf_seq = 16'h88EF;

    rst = 1'b0; en = 1'b0; tune_word = '0; mod_idx = 8'd0;
    in_data = 8'd0; in_valid = 1'b0; clr_underrun = 1'b0;
    #1 rst = 1'b1;

    // 1. reset state, carrier/sigma-delta startup, first tick underrun, clear
    step(M_RDY | M_UND | M_RF, 4'b1000);
    rst = 1'b0; en = 1'b1; tune_word = 24'h100000;
    for (int k = 1; k <= 64; k++)
      step(M_RDY | M_UND | ((k <= 16) ? M_RF : 4'b0000),
           {1'b1, (k == 64), 1'b0, rf_seq[(k <= 16) ? k - 1 : 0]});
    clr_underrun = 1'b1;
    step(M_RDY | M_UND, 4'b1000);
    clr_underrun = 1'b0;

    // 2. mod_idx=0: 75% / 25% ones density in the two carrier halves
    ones0 = 0; ones1 = 0;
    for (int j = 0; j < 128; j++) begin
      step(4'b0000, 4'b0000);
      idx = nco_k - 1;
      if (idx[3]) ones1 += int'(rf_out);
      else        ones0 += int'(rf_out);
    end
    check_range("density_75", ones0, 47, 49);
    check_range("density_25", ones1, 15, 17);

    // 3. full-scale positive sample: envelope 254, near-100% density in the positive half
    in_valid = 1'b1; in_data = 8'h7F; mod_idx = 8'd255; clr_underrun = 1'b1;
    act_q.push_back({8'd254, 8'h7F});
    step(M_RDY | M_UND, 4'b0000);
    in_valid = 1'b0; clr_underrun = 1'b0;
    check("env_before_tick", {24'd0, dut.env_q}, 32'd128);
    while (nco_k < 256)
      step(M_RDY | M_UND, {((nco_k + 1) == 256), 3'b000});
    ones0 = 0; ones1 = 0;
    for (int k = 257; k <= 322; k++) begin
      step(M_RDY | M_UND, {1'b1, (k >= 320), 2'b00});
      if (k >= 259) begin
        idx = k - 1;
        if (idx[3]) ones1 += int'(rf_out);
        else        ones0 += int'(rf_out);
      end
    end
    check_range("density_full_pos", ones0, 30, 32);
    check_range("density_full_neg", ones1, 0, 2);

    // 4. full-scale negative sample: envelope 0, rf_out alternates regardless of carrier
    in_valid = 1'b1; in_data = 8'h80; clr_underrun = 1'b1;
    act_q.push_back({8'd0, 8'h80});
    step(M_RDY | M_UND, 4'b0000);
    in_valid = 1'b0; clr_underrun = 1'b0;
    for (int k = 324; k <= 384; k++)
      step(M_RDY | M_UND, {(k == 384), 3'b000});
    repeat (8) step(4'b0000, 4'b0000);
    win = '0; ones0 = 0; ones1 = 0;
    for (int j = 0; j < 32; j++) begin
      step(4'b0000, 4'b0000);
      win[j] = rf_out;
      idx = nco_k - 1;
      if (idx[3]) ones1 += int'(rf_out);
      else        ones0 += int'(rf_out);
    end
    bad_pairs = 0;
    for (int p = 0; p < 16; p++)
      if (win[2*p] == win[2*p+1]) bad_pairs++;
    check("alternation_breaks", bad_pairs, 0);
    check("zero_env_ones_pos", ones0, 8);
    check("zero_env_ones_neg", ones1, 8);

    // 5. streaming with ready honoured over 8 sample periods, then a freeze
    idx = 0; clr_underrun = 1'b1;
    while (nco_k < 896) begin
      in_valid = (idx < 8);
      in_data  = seq[(idx < 8) ? idx : 0];
      acc_now  = in_valid && in_ready;
      if (acc_now) act_q.push_back({env_tab[idx], seq[idx]});
      step(M_UND, 4'b0000);
      clr_underrun = 1'b0;
      if (acc_now) idx++;
    end
    in_valid = 1'b0;
    check("samples_accepted", idx, 8);
    for (int k = 897; k <= 960; k++)
      step(M_UND, {1'b0, (k == 960), 2'b00});

    en = 1'b0; in_valid = 1'b1; in_data = 8'h33;
    rf_frz = rf_out;
    for (int j = 0; j < 10; j++) begin
      step(M_RDY | M_UND | M_RF, {1'b0, 1'b1, 1'b0, rf_frz});
      in_valid = 1'b0;
    end
    check("frozen_phase", {8'd0, dut.phase}, {8'd0, nco_k[3:0], 20'h0});
    check("frozen_div", {26'd0, dut.div}, {26'd0, nco_k[5:0]});

    // 6. asynchronous reset mid-period with the slot full, then a clean restart
    en = 1'b1;
    for (int k = 961; k <= 970; k++)
      step(M_RDY | M_UND, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("async_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_underrun", {31'd0, underrun}, 32'd0);
    check("async_carrier", {31'd0, carrier_out}, 32'd0);
    check("async_rf_out", {31'd0, rf_out}, 32'd0);
    act_q.delete();
    nco_k = 0;
    step(M_RDY | M_UND | M_RF, 4'b1000);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++)
      step(M_RDY | M_UND | M_RF, {1'b1, 1'b0, 1'b0, rf_seq[k-1]});
    in_valid = 1'b1; in_data = 8'h40;
    act_q.push_back({8'd191, 8'h40});
    step(M_RDY | M_UND, 4'b0000);
    in_valid = 1'b0;
    for (int k = 18; k <= 66; k++)
      step(M_RDY | M_UND, {(k >= 64), 3'b000});

    check("loads_pending", act_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
